// File: rtl/ddr_axi_traffic_checker_pkg.sv
// ddr_tc_pkg: shared types and constants for the DDR AXI traffic checker.
//   state_t     - checker FSM states
//   BURST_INCR  - AXI INCR burst encoding
//   RESP_OKAY   - AXI OKAY response encoding
//   LOCK_NORMAL - AXI normal (non-exclusive) access
//   size_of()   - AXI asize encoding for a given data width in bits
package ddr_tc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;

    function automatic logic [2:0] size_of(input int unsigned data_w);
        int unsigned bytes;
        logic [2:0]  sz;
        bytes = data_w / 8;
        sz    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                sz = 3'(i);
            end
        end
        return sz;
    endfunction

endpackage

// File: rtl/ddr_axi_traffic_checker_if.sv
// ddr_axi_traffic_checker_if: AXI-style bus between the traffic checker and
// one DDR controller target port. Shared address channel (atype selects
// write/read), write data, write response and read data channels.
//   master modport - traffic checker side
//   slave modport  - memory/controller side
interface ddr_axi_traffic_checker_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 8
);
    logic [ADDR_W-1:0]   aaddr;
    logic [1:0]          aburst;
    logic [ID_W-1:0]     aid;
    logic [7:0]          alen;
    logic [1:0]          alock;
    logic [2:0]          asize;
    logic                atype;
    logic                avalid;
    logic                aready;

    logic [DATA_W-1:0]   wdata;
    logic [ID_W-1:0]     wid;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic                bvalid;
    logic                bready;

    logic [DATA_W-1:0]   rdata;
    logic [ID_W-1:0]     rid;
    logic                rlast;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output aaddr, aburst, aid, alen, alock, asize, atype, avalid,
        input  aready,
        output wdata, wid, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bvalid,
        output bready,
        input  rdata, rid, rlast, rresp, rvalid,
        output rready
    );

    modport slave (
        input  aaddr, aburst, aid, alen, alock, asize, atype, avalid,
        output aready,
        input  wdata, wid, wstrb, wlast, wvalid,
        output wready,
        output bid, bvalid,
        input  bready,
        output rdata, rid, rlast, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/ddr_axi_traffic_checker_pattern.sv
// ddr_tc_pattern: combinational test pattern generator.
//   i_g    - global beat index (burst*BURST_LEN + beat)
//   o_word - DATA_W-bit word; 32-bit lane k = (i_g ^ SEED) + k
module ddr_tc_pattern #(
    parameter int unsigned DATA_W = 256,
    parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
    input  logic [31:0]       i_g,
    output logic [DATA_W-1:0] o_word
);

    localparam int unsigned LANES = DATA_W / 32;

    always_comb begin
        o_word = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            o_word[k*32 +: 32] = (i_g ^ SEED) + 32'(k);
        end
    end

endmodule

// File: rtl/ddr_axi_traffic_checker.sv
// ddr_axi_traffic_checker: writes NUM_BURSTS INCR bursts of a deterministic
// pattern to one DDR AXI target port, reads them back and checks every beat.
// Ports:
//   axi_clk    - clock for all logic
//   check_rstn - asynchronous active-low reset
//   start      - level; starts a pass when high in IDLE or DONE
//   inj_err    - (ERR_INJECT_EN only) sampled at start; flips wdata bit 0
//                on global beat 0
//   axi        - master side of ddr_axi_traffic_checker_if
//   done       - pass complete
//   pass       - valid with done; 1 when no errors were seen
//   err_count  - saturating error count
// Optional feature macro: ERR_INJECT_EN
module ddr_axi_traffic_checker
    import ddr_tc_pkg::*;
#(
    parameter int unsigned       DATA_W     = 256,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       ID_W       = 8,
    parameter int unsigned       BURST_LEN  = 16,
    parameter int unsigned       NUM_BURSTS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ID_W-1:0]   AXI_ID     = '0,
    parameter logic [31:0]       SEED       = 32'hA5A5_0000
) (
    input  logic                       axi_clk,
    input  logic                       check_rstn,
    input  logic                       start,
`ifdef ERR_INJECT_EN
    input  logic                       inj_err,
`endif
    ddr_axi_traffic_checker_if.master  axi,
    output logic                       done,
    output logic                       pass,
    output logic [15:0]                err_count
);

    localparam int unsigned BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam logic [8:0]  LAST_BEAT   = 9'(BURST_LEN - 1);
    localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_burst;
    logic [8:0]        r_beat;
    logic [15:0]       r_err;

    logic [31:0]       w_g;
    logic [DATA_W-1:0] w_wr_pat;
    logic [DATA_W-1:0] w_rd_exp;
    logic [DATA_W-1:0] w_wdata;
    logic              w_last_beat;
    logic              w_last_burst;
    logic              w_start;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_r_hs;
    logic              w_rd_fault;
    logic              w_err_inc;

    logic              w_avalid;
    logic              w_atype;
    logic              w_wvalid;
    logic              w_wlast;
    logic              w_bready;
    logic              w_rready;
    logic              w_done;

    // Write and read phases walk the same burst/beat counters, so both
    // pattern instances see the same global beat index.
    assign w_g          = r_burst * 32'(BURST_LEN) + 32'(r_beat);
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_last_burst = (r_burst == LAST_BURST);

    ddr_tc_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_pattern (
        .i_g    (w_g),
        .o_word (w_wr_pat)
    );

    ddr_tc_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_rd_pattern (
        .i_g    (w_g),
        .o_word (w_rd_exp)
    );

`ifdef ERR_INJECT_EN
    logic r_inj;
    assign w_wdata = w_wr_pat ^ {{(DATA_W-1){1'b0}}, (r_inj && (w_g == '0))};
`else
    assign w_wdata = w_wr_pat;
`endif

    assign w_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_w_hs  = (r_state == ST_WR_DATA) && axi.wready;
    assign w_b_hs  = (r_state == ST_WR_RESP) && axi.bvalid;
    assign w_r_hs  = (r_state == ST_RD_DATA) && axi.rvalid;

    // Any combination of faults on one beat counts once.
    assign w_rd_fault = (axi.rdata != w_rd_exp) || (axi.rresp != RESP_OKAY) ||
                        (axi.rid != AXI_ID) || (axi.rlast != w_last_beat);
    assign w_err_inc  = (w_b_hs && (axi.bid != AXI_ID)) || (w_r_hs && w_rd_fault);

    always_ff @(posedge axi_clk or negedge check_rstn) begin
        if (!check_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_avalid = 1'b0;
        w_atype  = 1'b0;
        w_wvalid = 1'b0;
        w_wlast  = 1'b0;
        w_bready = 1'b0;
        w_rready = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                w_avalid = 1'b1;
                w_atype  = 1'b1;
                if (axi.aready) w_next = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                w_wvalid = 1'b1;
                w_wlast  = w_last_beat;
                if (axi.wready && w_last_beat) w_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                w_bready = 1'b1;
                if (axi.bvalid) w_next = w_last_burst ? ST_RD_ADDR : ST_WR_ADDR;
            end
            ST_RD_ADDR: begin
                w_avalid = 1'b1;
                if (axi.aready) w_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                w_rready = 1'b1;
                if (axi.rvalid && w_last_beat) w_next = w_last_burst ? ST_DONE : ST_RD_ADDR;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (start) w_next = ST_WR_ADDR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge check_rstn) begin
        if (!check_rstn) begin
            r_burst <= '0;
            r_beat  <= '0;
            r_err   <= '0;
`ifdef ERR_INJECT_EN
            r_inj   <= 1'b0;
`endif
        end else if (w_start) begin
            r_burst <= '0;
            r_beat  <= '0;
            r_err   <= '0;
`ifdef ERR_INJECT_EN
            r_inj   <= inj_err;
`endif
        end else begin
            if (w_w_hs || w_r_hs) begin
                r_beat <= w_last_beat ? '0 : r_beat + 9'd1;
            end
            // Burst counter wraps to 0 after the write phase so reads
            // restart at BASE_ADDR.
            if (w_b_hs || (w_r_hs && w_last_beat)) begin
                r_burst <= w_last_burst ? '0 : r_burst + 32'd1;
            end
            if (w_err_inc && (r_err != '1)) begin
                r_err <= r_err + 16'd1;
            end
        end
    end

    assign axi.aaddr  = BASE_ADDR + ADDR_W'(r_burst) * ADDR_W'(BURST_BYTES);
    assign axi.aburst = BURST_INCR;
    assign axi.aid    = AXI_ID;
    assign axi.alen   = 8'(BURST_LEN - 1);
    assign axi.alock  = LOCK_NORMAL;
    assign axi.asize  = size_of(DATA_W);
    assign axi.atype  = w_atype;
    assign axi.avalid = w_avalid;
    assign axi.wdata  = w_wvalid ? w_wdata : '0;
    assign axi.wid    = AXI_ID;
    assign axi.wstrb  = '1;
    assign axi.wlast  = w_wlast;
    assign axi.wvalid = w_wvalid;
    assign axi.bready = w_bready;
    assign axi.rready = w_rready;

    assign done      = w_done;
    assign pass      = w_done && (r_err == '0);
    assign err_count = r_err;

endmodule

// File: tb/tb_ddr_axi_traffic_checker.sv
// Bench for ddr_axi_traffic_checker: one 256-bit and one 128-bit instance,
// each attached to a behavioural memory that stores written beats and plays
// them back, with optional random backpressure and fault insertion.
module tb_ddr_axi_traffic_checker;

    localparam int unsigned BL   = 16;
    localparam int unsigned NB   = 4;
    localparam logic [31:0] SEED = 32'hA5A5_0000;
    localparam logic [7:0]  ID   = 8'h5A;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [2] = '{1'b0, 1'b0};
    logic        start [2] = '{1'b0, 1'b0};
    logic        inj   [2] = '{1'b0, 1'b0};
    logic        done  [2];
    logic        pass  [2];
    logic [15:0] errc  [2];

    bit          bp_en [2] = '{1'b0, 1'b0};
    bit          corrupt_en   = 1'b0;
    bit          rresp_bad_en = 1'b0;

    int          stall_viol [2] = '{0, 0};
    int          wdata_bad  [2] = '{0, 0};
    int          wbeats     [2] = '{0, 0};
    logic [31:0] addr_log [$];
    bit          type_log [$];

    int          errors = 0;
    int          checks = 0;

    // Expected pattern: lane k of global beat g is (g ^ SEED) + k.
    function automatic logic [255:0] ref_word(input int unsigned g, input int unsigned dw);
        logic [255:0] w;
        w = '0;
        for (int unsigned k = 0; k < dw / 32; k++) begin
            w[k*32 +: 32] = (g ^ SEED) + k;
        end
        return w;
    endfunction

    for (genvar c = 0; c < 2; c++) begin : g_cfg
        localparam int unsigned DW = (c == 0) ? 256 : 128;
        localparam int unsigned BB = BL * DW / 8;

        ddr_axi_traffic_checker_if #(.DATA_W(DW), .ADDR_W(32), .ID_W(8)) bus ();

        ddr_axi_traffic_checker #(
            .DATA_W(DW), .ADDR_W(32), .ID_W(8), .BURST_LEN(BL), .NUM_BURSTS(NB),
            .BASE_ADDR(32'h0), .AXI_ID(ID), .SEED(SEED)
        ) dut (
            .axi_clk    (clk),
            .check_rstn (rstn[c]),
            .start      (start[c]),
`ifdef ERR_INJECT_EN
            .inj_err    (inj[c]),
`endif
            .axi        (bus),
            .done       (done[c]),
            .pass       (pass[c]),
            .err_count  (errc[c])
        );

        logic [DW-1:0] mem [longint];
        logic [31:0]   wr_addr = '0;
        int unsigned   wr_beat = 0;
        int unsigned   b_pend  = 0;
        logic [31:0]   rq_addr [$];
        int unsigned   rq_beat [$];
        bit            prev_astall = 1'b0;
        bit            prev_wstall = 1'b0;
        logic [31:0]   prev_aaddr;
        logic          prev_atype;
        logic [DW-1:0] prev_wdata;
        logic          prev_wlast;

        // Inputs change on the falling edge; handshakes that will complete
        // on the next rising edge are accounted for here as well, since the
        // checker's outputs only depend on its registers.
        always @(negedge clk) begin
            logic [255:0] full;
            logic [DW-1:0] d;
            int unsigned   g;
            if (!rstn[c]) begin
                bus.aready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
                bus.bid = ID; bus.rvalid = 1'b0; bus.rdata = '0; bus.rid = ID;
                bus.rlast = 1'b0; bus.rresp = 2'b00;
                rq_addr.delete(); rq_beat.delete();
                b_pend = 0; wr_beat = 0; prev_astall = 1'b0; prev_wstall = 1'b0;
            end else begin
                if (prev_astall && (!bus.avalid || bus.aaddr !== prev_aaddr || bus.atype !== prev_atype))
                    stall_viol[c]++;
                if (prev_wstall && (!bus.wvalid || bus.wdata !== prev_wdata || bus.wlast !== prev_wlast))
                    stall_viol[c]++;

                bus.aready = bp_en[c] ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.wready = bp_en[c] ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.bvalid = (b_pend != 0);
                bus.bid    = ID;
                if (rq_addr.size() != 0 && (!bp_en[c] || $urandom_range(0, 1) == 1)) begin
                    d = mem.exists(longint'(rq_addr[0]) + longint'(rq_beat[0] * DW / 8)) ?
                        mem[longint'(rq_addr[0]) + longint'(rq_beat[0] * DW / 8)] : '0;
                    if (corrupt_en && c == 0 && rq_addr[0] / BB == 2 && rq_beat[0] == 3)
                        d[7] = ~d[7];
                    bus.rvalid = 1'b1;
                    bus.rdata  = d;
                    bus.rid    = ID;
                    bus.rlast  = (rq_beat[0] == BL - 1);
                    bus.rresp  = (rresp_bad_en && c == 0 && rq_addr[0] / BB == 0) ? 2'b10 : 2'b00;
                end else begin
                    bus.rvalid = 1'b0;
                    bus.rdata  = '0;
                    bus.rlast  = 1'b0;
                    bus.rresp  = 2'b00;
                end

                prev_astall = bus.avalid && !bus.aready;
                prev_aaddr  = bus.aaddr;
                prev_atype  = bus.atype;
                prev_wstall = bus.wvalid && !bus.wready;
                prev_wdata  = bus.wdata;
                prev_wlast  = bus.wlast;

                if (bus.avalid && bus.aready) begin
                    if (c == 0) begin
                        addr_log.push_back(bus.aaddr);
                        type_log.push_back(bus.atype);
                    end
                    if (bus.atype) begin
                        wr_addr = bus.aaddr;
                        wr_beat = 0;
                    end else begin
                        for (int unsigned b = 0; b < BL; b++) begin
                            rq_addr.push_back(bus.aaddr);
                            rq_beat.push_back(b);
                        end
                    end
                end
                if (bus.wvalid && bus.wready) begin
                    g    = (wr_addr / BB) * BL + wr_beat;
                    full = ref_word(g, DW);
                    d    = full[DW-1:0];
                    if (inj[c] && g == 0) d[0] = ~d[0];
                    if (bus.wdata !== d || bus.wlast !== (wr_beat == BL - 1)) wdata_bad[c]++;
                    mem[longint'(wr_addr) + longint'(wr_beat * DW / 8)] = bus.wdata;
                    wbeats[c]++;
                    if (wr_beat == BL - 1) b_pend++;
                    wr_beat++;
                end
                if (bus.bvalid && bus.bready) b_pend--;
                if (bus.rvalid && bus.rready) begin
                    void'(rq_addr.pop_front());
                    void'(rq_beat.pop_front());
                end
            end
        end
    end

    task automatic wait_done(input int c, input string tag);
        int n;
        n = 0;
        while (!done[c] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done[c] !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, done[c], n);
        end
    endtask

    task automatic run_pass(input int c, input int exp_err, input bit exp_pass, input string tag);
        stall_viol[c] = 0;
        wdata_bad[c]  = 0;
        wbeats[c]     = 0;
        @(negedge clk);
        start[c] = 1'b1;
        @(negedge clk);
        start[c] = 1'b0;
        wait_done(c, tag);
        checks++;
        if (errc[c] !== 16'(exp_err)) begin
            errors++;
            $display("FAIL %s_err_count: got %0d, required %0d", tag, errc[c], exp_err);
        end
        checks++;
        if (pass[c] !== exp_pass) begin
            errors++;
            $display("FAIL %s_pass: got %b, required %b", tag, pass[c], exp_pass);
        end
        checks++;
        if (stall_viol[c] !== 0) begin
            errors++;
            $display("FAIL %s_stall_stable: %0d changes while stalled, required 0", tag, stall_viol[c]);
        end
        checks++;
        if (wdata_bad[c] !== 0 || wbeats[c] !== int'(BL * NB)) begin
            errors++;
            $display("FAIL %s_wdata: %0d bad of %0d beats, required 0 of %0d", tag, wdata_bad[c], wbeats[c], BL * NB);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (done[c] !== 1'b0 || pass[c] !== 1'b0 || errc[c] !== 16'd0) begin
                errors++;
                $display("FAIL reset_status%0d: done=%b pass=%b err=%0d, required 0 0 0", c, done[c], pass[c], errc[c]);
            end
        end
        checks++;
        if (g_cfg[0].bus.avalid !== 1'b0 || g_cfg[0].bus.wvalid !== 1'b0 ||
            g_cfg[0].bus.bready !== 1'b0 || g_cfg[0].bus.rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: avalid=%b wvalid=%b bready=%b rready=%b, required 0000",
                     g_cfg[0].bus.avalid, g_cfg[0].bus.wvalid, g_cfg[0].bus.bready, g_cfg[0].bus.rready);
        end
        checks++;
        if (g_cfg[0].bus.aaddr !== 32'h0 || g_cfg[0].bus.atype !== 1'b0 ||
            g_cfg[0].bus.wlast !== 1'b0 || g_cfg[0].bus.wdata !== 256'h0) begin
            errors++;
            $display("FAIL reset_outputs: aaddr=%h atype=%b wlast=%b wdata_nonzero=%b, required 0 0 0 0",
                     g_cfg[0].bus.aaddr, g_cfg[0].bus.atype, g_cfg[0].bus.wlast, |g_cfg[0].bus.wdata);
        end
        checks++;
        if (g_cfg[0].bus.aburst !== 2'b01 || g_cfg[0].bus.alen !== 8'd15 || g_cfg[0].bus.asize !== 3'd5 ||
            g_cfg[1].bus.asize !== 3'd4 || g_cfg[0].bus.aid !== ID || g_cfg[0].bus.wstrb !== '1) begin
            errors++;
            $display("FAIL reset_constants: aburst=%b alen=%0d asize=%0d/%0d aid=%h, required 01 15 5/4 %h",
                     g_cfg[0].bus.aburst, g_cfg[0].bus.alen, g_cfg[0].bus.asize, g_cfg[1].bus.asize,
                     g_cfg[0].bus.aid, ID);
        end
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
    endtask

    task automatic test_ideal();
        addr_log.delete();
        type_log.delete();
        bp_en[0] = 1'b0;
        run_pass(0, 0, 1'b1, "ideal");
        checks++;
        if (addr_log.size() != 2 * NB) begin
            errors++;
            $display("FAIL ideal_addr_count: got %0d, required %0d", addr_log.size(), 2 * NB);
        end else begin
            for (int i = 0; i < int'(2 * NB); i++) begin
                checks++;
                if (addr_log[i] !== 32'((i % NB) * 32'h200) || type_log[i] !== (i < int'(NB))) begin
                    errors++;
                    $display("FAIL ideal_addr%0d: got %h type %b, required %h type %b", i, addr_log[i],
                             type_log[i], (i % NB) * 32'h200, (i < int'(NB)));
                end
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done[0] !== 1'b1 || pass[0] !== 1'b1) begin
            errors++;
            $display("FAIL ideal_done_hold: done=%b pass=%b, required 1 1", done[0], pass[0]);
        end
    endtask

    task automatic test_backpressure();
        bp_en[1] = 1'b1;
        run_pass(1, 0, 1'b1, "backpressure");
        bp_en[1] = 1'b0;
    endtask

    task automatic test_corrupt();
        corrupt_en = 1'b1;
        run_pass(0, 1, 1'b0, "corrupt");
        corrupt_en = 1'b0;
    endtask

    task automatic test_rresp();
        rresp_bad_en = 1'b1;
        run_pass(0, 16, 1'b0, "rresp");
        rresp_bad_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start[0] = 1'b1;
        wait_done(0, "b2b_first");
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0 || g_cfg[0].bus.avalid !== 1'b1 || g_cfg[0].bus.atype !== 1'b1 ||
            g_cfg[0].bus.aaddr !== 32'h0) begin
            errors++;
            $display("FAIL b2b_restart: done=%b avalid=%b atype=%b aaddr=%h, required 0 1 1 0",
                     done[0], g_cfg[0].bus.avalid, g_cfg[0].bus.atype, g_cfg[0].bus.aaddr);
        end
        start[0] = 1'b0;
        wait_done(0, "b2b_second");
        checks++;
        if (pass[0] !== 1'b1 || errc[0] !== 16'd0) begin
            errors++;
            $display("FAIL b2b_pass: pass=%b err=%0d, required 1 0", pass[0], errc[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wbeats[0] = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (wbeats[0] != 5 && n < 2000);
        checks++;
        if (wbeats[0] != 5 || g_cfg[0].bus.wvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reach: beats=%0d wvalid=%b, required 5 1", wbeats[0], g_cfg[0].bus.wvalid);
        end
        rstn[0] = 1'b0;
        #1;
        checks++;
        if (g_cfg[0].bus.avalid !== 1'b0 || g_cfg[0].bus.wvalid !== 1'b0 ||
            g_cfg[0].bus.bready !== 1'b0 || g_cfg[0].bus.rready !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_valids: avalid=%b wvalid=%b bready=%b rready=%b done=%b, required 00000",
                     g_cfg[0].bus.avalid, g_cfg[0].bus.wvalid, g_cfg[0].bus.bready,
                     g_cfg[0].bus.rready, done[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rstn[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (g_cfg[0].bus.avalid !== 1'b0 || done[0] !== 1'b0 || errc[0] !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_idle: avalid=%b done=%b err=%0d, required 0 0 0",
                     g_cfg[0].bus.avalid, done[0], errc[0]);
        end
        run_pass(0, 0, 1'b1, "after_reset");
    endtask

    task automatic test_inject();
        inj[0] = 1'b1;
        run_pass(0, 1, 1'b0, "inject_on");
        inj[0] = 1'b0;
        run_pass(0, 0, 1'b1, "inject_off");
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_backpressure();
        test_corrupt();
        test_rresp();
        test_back_to_back();
        test_reset_mid();
`ifdef ERR_INJECT_EN
        test_inject();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
